// File: rtl/axi_aw_issue.sv
// AXI write-address issue stage: request FIFO, AW output register with
// VALID/READY hold, and an outstanding-write credit counter fed by B handshakes.
module axi_aw_issue #(
    parameter int DEPTH           = 16,
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ID_WIDTH-1:0]                req_id,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [7:0]                         req_len,
    input  logic [2:0]                         req_size,
    input  logic [1:0]                         req_burst,
    output logic [ID_WIDTH-1:0]                axi_awid,
    output logic [ADDR_WIDTH-1:0]              axi_awaddr,
    output logic [7:0]                         axi_awlen,
    output logic [2:0]                         axi_awsize,
    output logic [1:0]                         axi_awburst,
    output logic                               axi_awvalid,
    input  logic                               axi_awready,
    input  logic                               axi_bvalid,
    input  logic                               axi_bready,
    output logic [$clog2(DEPTH+1)-1:0]         fifo_count,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                               b_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PAY_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

    localparam logic [OST_W-1:0] OST_MAX  = OST_W'(MAX_OUTSTANDING);
    localparam logic [OST_W-1:0] OST_ZERO = {OST_W{1'b0}};
    localparam logic [OST_W-1:0] OST_ONE  = {{(OST_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

    logic [PAY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PAY_W-1:0] aw_pay_r;
    logic             aw_valid_r;
    logic [OST_W-1:0] outstanding_r;
    logic             b_underflow_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             load_s;
    logic             slot_free_s;
    logic             credit_ok_s;
    logic             b_hs_s;
    logic [PAY_W-1:0] req_pay_s;
    logic [PAY_W-1:0] head_pay_s;
    logic [OST_W-1:0] ost_next_s;
    logic             underflow_set_s;

    // The extra pointer MSB separates the full and empty cases at equal indices.
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    assign req_ready   = !full_s && !rst;
    assign push_s      = req_valid && req_ready;
    assign slot_free_s = !aw_valid_r || axi_awready;
    assign credit_ok_s = (outstanding_r < OST_MAX);
    assign load_s      = slot_free_s && !empty_s && credit_ok_s;
    assign b_hs_s      = axi_bvalid && axi_bready;

    assign req_pay_s  = {req_id, req_addr, req_len, req_size, req_burst};
    assign head_pay_s = mem[rd_ptr_r[PTR_W-1:0]];

    assign {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst} = aw_pay_r;
    assign axi_awvalid = aw_valid_r;
    assign fifo_count  = CNT_W'(wr_ptr_r - rd_ptr_r);
    assign outstanding = outstanding_r;
    assign b_underflow = b_underflow_r;

    // FIFO storage write port; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r[PTR_W-1:0]] <= req_pay_s;
        end
    end

    // FIFO pointers: a load into the output register is the only pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // AW output register: only changes when the slot is free, so VALID and
    // payload stay frozen while the slave withholds READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_valid_r <= 1'b0;
            aw_pay_r   <= {PAY_W{1'b0}};
        end else if (slot_free_s) begin
            aw_valid_r <= load_s;
            if (load_s) begin
                aw_pay_r <= head_pay_s;
            end
        end
    end

    // Credit bookkeeping: a load takes a credit, a B handshake returns one.
    always_comb begin
        ost_next_s      = outstanding_r;
        underflow_set_s = 1'b0;
        case ({load_s, b_hs_s})
            2'b10: ost_next_s = outstanding_r + OST_ONE;
            2'b01: begin
                if (outstanding_r == OST_ZERO) begin
                    underflow_set_s = 1'b1;
                end else begin
                    ost_next_s = outstanding_r - OST_ONE;
                end
            end
            default: ost_next_s = outstanding_r;
        endcase
    end

    // Credit counter and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= OST_ZERO;
            b_underflow_r <= 1'b0;
        end else begin
            outstanding_r <= ost_next_s;
            if (underflow_set_s) begin
                b_underflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_aw_issue.sv
// Scoreboard bench for axi_aw_issue: accepted requests are queued and
// checked in order against every AW handshake.
module tb_axi_aw_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_id;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic [7:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [4:0]  fifo_count;
    logic [3:0]  outstanding;
    logic        b_underflow;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;

    aw_t sb_q[$];
    aw_t mon_exp;
    aw_t mon_act;
    int  tests    = 0;
    int  fails    = 0;
    int  hs_count = 0;

    always #5 clk = ~clk;

    axi_aw_issue #(
        .DEPTH(16), .ID_WIDTH(8), .ADDR_WIDTH(32), .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .fifo_count(fifo_count), .outstanding(outstanding),
        .b_underflow(b_underflow)
    );

    // Scoreboard: inputs are stable mid-cycle, so negedge sees the coming edge's handshakes.
    always @(negedge clk) begin
        if (!rst && axi_awvalid && axi_awready) begin
            hs_count++;
            tests++;
            mon_act = {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL aw_unexpected: got id=%h addr=%h, scoreboard empty", axi_awid, axi_awaddr);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL aw_order: got %h, expected %h", mon_act, mon_exp);
                end
            end
        end
        if (!rst && req_valid && req_ready) begin
            sb_q.push_back({req_id, req_addr, req_len, req_size, req_burst});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [7:0] id, input logic [31:0] addr);
        req_valid = 1'b1;
        req_id    = id;
        req_addr  = addr;
        req_len   = id ^ 8'h5a;
        req_size  = id[2:0];
        req_burst = 2'b01;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        req_valid   = 1'b0;
        axi_awready = 1'b1;
        axi_bready  = 1'b1;
        while ((sb_q.size() != 0 || outstanding != 4'd0 || axi_awvalid) && n < 300) begin
            axi_bvalid = (outstanding != 4'd0);
            tick();
            n++;
        end
        axi_bvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_awready = 1'b0;
        ok = (n < 300);
    endtask

    task automatic check_drained(input string name);
        bit ok;
        drain(ok);
        tests++;
        if (!ok || fifo_count !== 5'd0 || outstanding !== 4'd0 || axi_awvalid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: ok=%0d fifo=%0d outst=%0d awvalid=%b, required 1/0/0/0",
                     name, ok, fifo_count, outstanding, axi_awvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_id = 8'h00; req_addr = 32'h0;
        req_len = 8'h00; req_size = 3'd0; req_burst = 2'd0;
        axi_awready = 1'b0; axi_bvalid = 1'b0; axi_bready = 1'b0;
        tick(); tick();
        tests++;
        if (axi_awvalid !== 1'b0 || axi_awid !== 8'h00 || axi_awaddr !== 32'h0 ||
            axi_awlen !== 8'h00 || axi_awsize !== 3'd0 || axi_awburst !== 2'd0) begin
            fails++;
            $display("FAIL reset_aw: awvalid=%b id=%h addr=%h, required all zero", axi_awvalid, axi_awid, axi_awaddr);
        end
        tests++;
        if (fifo_count !== 5'd0 || outstanding !== 4'd0 || b_underflow !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: fifo=%0d outst=%0d uf=%b ready=%b, required 0/0/0/0",
                     fifo_count, outstanding, b_underflow, req_ready);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_basic_order();
        int hs0 = hs_count;
        axi_awready = 1'b1;
        set_req(8'h11, 32'h0000_1100);
        tick();
        tests++;
        if (axi_awvalid !== 1'b0 || fifo_count !== 5'd1) begin
            fails++;
            $display("FAIL basic_latency0: awvalid=%b fifo=%0d, required 0/1", axi_awvalid, fifo_count);
        end
        set_req(8'h22, 32'h0000_2200);
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h11) begin
            fails++;
            $display("FAIL basic_first: awvalid=%b id=%h, required 1/11", axi_awvalid, axi_awid);
        end
        set_req(8'h33, 32'h0000_3300);
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h22) begin
            fails++;
            $display("FAIL basic_second: awvalid=%b id=%h, required 1/22", axi_awvalid, axi_awid);
        end
        req_valid = 1'b0;
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h33) begin
            fails++;
            $display("FAIL basic_third: awvalid=%b id=%h, required 1/33", axi_awvalid, axi_awid);
        end
        tick();
        tests++;
        if (axi_awvalid !== 1'b0 || fifo_count !== 5'd0 || outstanding !== 4'd3 || hs_count - hs0 != 3) begin
            fails++;
            $display("FAIL basic_end: awvalid=%b fifo=%0d outst=%0d hs=%0d, required 0/0/3/3",
                     axi_awvalid, fifo_count, outstanding, hs_count - hs0);
        end
        check_drained("basic");
    endtask

    task automatic test_backpressure();
        int hs0;
        axi_awready = 1'b0;
        set_req(8'h44, 32'h1000_0040);
        tick();
        req_valid = 1'b0;
        tick();
        hs0 = hs_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (axi_awvalid !== 1'b1 || axi_awid !== 8'h44 || axi_awaddr !== 32'h1000_0040 ||
                axi_awlen !== 8'h1e || axi_awsize !== 3'd4 || axi_awburst !== 2'b01) begin
                fails++;
                $display("FAIL hold_cycle%0d: awvalid=%b id=%h addr=%h len=%h size=%0d burst=%0d, required 1/44/10000040/1e/4/1",
                         i, axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst);
            end
        end
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        tick(); tick();
        tests++;
        if (hs_count - hs0 != 1 || axi_awvalid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: handshakes=%0d awvalid=%b, required 1/0", hs_count - hs0, axi_awvalid);
        end
        check_drained("hold");
    endtask

    task automatic test_full();
        int acc = 0;
        axi_awready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_req(8'h40 + 8'(i), 32'h2000_0000 + 32'(i * 4));
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        tests++;
        if (acc != 17 || req_ready !== 1'b0 || fifo_count !== 5'd16 || axi_awvalid !== 1'b1) begin
            fails++;
            $display("FAIL full_capacity: accepted=%0d ready=%b fifo=%0d awvalid=%b, required 17/0/16/1",
                     acc, req_ready, fifo_count, axi_awvalid);
        end
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || fifo_count !== 5'd15) begin
            fails++;
            $display("FAIL full_release: ready=%b fifo=%0d, required 1/15", req_ready, fifo_count);
        end
        check_drained("full");
    endtask

    task automatic test_credit();
        int hs0 = hs_count;
        axi_awready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req(8'h60 + 8'(i), 32'h3000_0000 + 32'(i * 64));
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if (hs_count - hs0 != 8 || outstanding !== 4'd8 || axi_awvalid !== 1'b0 || fifo_count !== 5'd4) begin
            fails++;
            $display("FAIL credit_stall: hs=%0d outst=%0d awvalid=%b fifo=%0d, required 8/8/0/4",
                     hs_count - hs0, outstanding, axi_awvalid, fifo_count);
        end
        axi_bvalid = 1'b1; axi_bready = 1'b1; axi_awready = 1'b0;
        tick();
        axi_bvalid = 1'b0; axi_bready = 1'b0;
        tests++;
        if (axi_awvalid !== 1'b0 || outstanding !== 4'd7) begin
            fails++;
            $display("FAIL credit_b_edge: awvalid=%b outst=%0d, required 0/7", axi_awvalid, outstanding);
        end
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h68 || outstanding !== 4'd8) begin
            fails++;
            $display("FAIL credit_ninth: awvalid=%b id=%h outst=%0d, required 1/68/8", axi_awvalid, axi_awid, outstanding);
        end
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        axi_bvalid = 1'b1; axi_bready = 1'b1;
        tick();
        tests++;
        if (axi_awvalid !== 1'b0 || outstanding !== 4'd7) begin
            fails++;
            $display("FAIL credit_second_b: awvalid=%b outst=%0d, required 0/7", axi_awvalid, outstanding);
        end
        tick();
        axi_bvalid = 1'b0; axi_bready = 1'b0;
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h69 || outstanding !== 4'd7) begin
            fails++;
            $display("FAIL credit_concurrent: awvalid=%b id=%h outst=%0d, required 1/69/7", axi_awvalid, axi_awid, outstanding);
        end
        check_drained("credit");
    endtask

    task automatic test_underflow();
        axi_bvalid = 1'b1; axi_bready = 1'b1;
        tick();
        axi_bvalid = 1'b0; axi_bready = 1'b0;
        tests++;
        if (outstanding !== 4'd0 || b_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow_set: outst=%0d uf=%b, required 0/1", outstanding, b_underflow);
        end
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (b_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow_sticky: uf=%b, required 1", b_underflow);
        end
    endtask

    task automatic test_reset_midrun();
        int hs0;
        axi_awready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(8'h80 + 8'(i), 32'h4000_0000 + 32'(i));
            tick();
        end
        req_valid = 1'b0;
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || fifo_count !== 5'd5) begin
            fails++;
            $display("FAIL midrun_setup: awvalid=%b fifo=%0d, required 1/5", axi_awvalid, fifo_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        tests++;
        if (axi_awvalid !== 1'b0 || fifo_count !== 5'd0 || outstanding !== 4'd0 || b_underflow !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: awvalid=%b fifo=%0d outst=%0d uf=%b, required 0/0/0/0",
                     axi_awvalid, fifo_count, outstanding, b_underflow);
        end
        hs0 = hs_count;
        axi_awready = 1'b1;
        set_req(8'h99, 32'h5000_0000);
        tick();
        req_valid = 1'b0;
        tick();
        tests++;
        if (axi_awvalid !== 1'b1 || axi_awid !== 8'h99) begin
            fails++;
            $display("FAIL midrun_new: awvalid=%b id=%h, required 1/99", axi_awvalid, axi_awid);
        end
        tick(); tick();
        tests++;
        if (hs_count - hs0 != 1 || axi_awvalid !== 1'b0 || sb_q.size() != 0) begin
            fails++;
            $display("FAIL midrun_single: hs=%0d awvalid=%b sb=%0d, required 1/0/0",
                     hs_count - hs0, axi_awvalid, sb_q.size());
        end
        check_drained("midrun");
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_backpressure();
        test_full();
        test_credit();
        test_underflow();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
